// File: rtl/encoder4to2_event_queue.sv
// Event-capturing priority encoder: latches request pulses as pending lines and
// presents the highest pending index, one at a time, over a valid/ready output.
module encoder4to2_event_queue #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [N-1:0]     pend_o,
    output logic             ovf_o,
    input  logic             ovf_clr_i
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d, take_mask;
    logic [IDX_W-1:0] idx_q, idx_d, enc;
    logic             ovf_q, ovf_d, ovf_set;
    logic             any_pend, load;

    assign any_pend = |pend_q;

    // ascending scan so the highest set line is the last one written
    always_comb begin
        enc = '0;
        for (int k = 0; k < N; k++) begin
            if (pend_q[k]) enc = IDX_W'(k);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (any_pend) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (out_rdy_i) begin
                    if (any_pend) load = 1'b1;
                    else          state_d = EMPTY;
                end
            end
        endcase
    end

    always_comb begin
        take_mask = '0;
        if (load) take_mask[enc] = 1'b1;
    end

    assign idx_d = load ? enc : idx_q;

    // a line being taken this edge absorbs a fresh event without overflow
    assign ovf_set = |(req_i & pend_q & ~take_mask);
    assign pend_d  = (pend_q & ~take_mask) | req_i;
    assign ovf_d   = ovf_set | (ovf_q & ~ovf_clr_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pend_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_idx_o = idx_q;
    assign out_vld_o = (state_q == FULL);
    assign pend_o    = pend_q;
    assign ovf_o     = ovf_q;

endmodule
